// File: rtl/alu_op_issue.sv
// ID/EX issue stage: opcode encode, operand select, result forwarding, 2-entry output/skid buffer.
// Optional ALU_OP_ISSUE_PERF_EN adds perf_issued / perf_stall event counters.
module alu_op_issue #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 16,
   parameter int RA_W  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_func,
   input  logic [WIDTH-1:0] in_rs_data,
   input  logic [WIDTH-1:0] in_rt_data,
   input  logic [IMM_W-1:0] in_imm,
   input  logic             in_use_imm,
   input  logic             in_rs_fwd,
   input  logic             in_rt_fwd,
   input  logic [RA_W-1:0]  in_dest,
   output logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] data2,
   output logic [3:0]       aluoperation,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [RA_W-1:0]  ex_dest,
   input  logic [WIDTH-1:0] alu_result
`ifdef ALU_OP_ISSUE_PERF_EN
   ,
   output logic [31:0]      perf_issued,
   output logic [31:0]      perf_stall
`endif
);

   logic             skid_valid;
   logic [2:0]       skid_func;
   logic [WIDTH-1:0] skid_rs;
   logic [WIDTH-1:0] skid_rt;
   logic [IMM_W-1:0] skid_imm;
   logic             skid_use_imm;
   logic             skid_rs_fwd;
   logic             skid_rt_fwd;
   logic [RA_W-1:0]  skid_dest;
   logic [WIDTH-1:0] last_result;

   logic             accept;
   logic             fire;
   logic             from_skid;
   logic             load_in;
   logic             to_skid;
   logic [WIDTH-1:0] fwd_val;

   logic [2:0]       sel_func;
   logic [WIDTH-1:0] sel_rs;
   logic [WIDTH-1:0] sel_rt;
   logic [IMM_W-1:0] sel_imm;
   logic             sel_use_imm;
   logic             sel_rs_fwd;
   logic             sel_rt_fwd;
   logic [RA_W-1:0]  sel_dest;
   logic [WIDTH-1:0] nxt_d1;
   logic [WIDTH-1:0] nxt_d2;
   logic [3:0]       nxt_op;

   assign accept    = in_valid & in_ready;
   assign fire      = ex_valid & ex_ready;
   assign from_skid = skid_valid & fire;
   // in_ready implies an empty skid, so load_in and from_skid never coincide
   assign load_in   = accept & (~ex_valid | fire);
   assign to_skid   = accept & ex_valid & ~fire;
   // the producer of a dependent op is the one leaving EX now, or the last one that left
   assign fwd_val   = fire ? alu_result : last_result;

   always_comb begin
      sel_func    = in_func;
      sel_rs      = in_rs_data;
      sel_rt      = in_rt_data;
      sel_imm     = in_imm;
      sel_use_imm = in_use_imm;
      sel_rs_fwd  = in_rs_fwd;
      sel_rt_fwd  = in_rt_fwd;
      sel_dest    = in_dest;
      if (from_skid) begin
         sel_func    = skid_func;
         sel_rs      = skid_rs;
         sel_rt      = skid_rt;
         sel_imm     = skid_imm;
         sel_use_imm = skid_use_imm;
         sel_rs_fwd  = skid_rs_fwd;
         sel_rt_fwd  = skid_rt_fwd;
         sel_dest    = skid_dest;
      end
   end

   always_comb begin
      nxt_d1 = sel_rs_fwd ? fwd_val : sel_rs;
      if (sel_use_imm)
         nxt_d2 = {{(WIDTH-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
      else if (sel_rt_fwd)
         nxt_d2 = fwd_val;
      else
         nxt_d2 = sel_rt;
      case (sel_func)
         3'd1:    nxt_op = 4'b0001;
         3'd2:    nxt_op = 4'b0010;
         3'd3:    nxt_op = 4'b0011;
         3'd4:    nxt_op = 4'b0100;
         default: nxt_op = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         data1        <= '0;
         data2        <= '0;
         aluoperation <= 4'b0000;
         ex_dest      <= '0;
         last_result  <= '0;
         in_ready     <= 1'b1;
         skid_valid   <= 1'b0;
         skid_func    <= '0;
         skid_rs      <= '0;
         skid_rt      <= '0;
         skid_imm     <= '0;
         skid_use_imm <= 1'b0;
         skid_rs_fwd  <= 1'b0;
         skid_rt_fwd  <= 1'b0;
         skid_dest    <= '0;
      end else begin
         if (fire)
            last_result <= alu_result;

         if (from_skid || load_in) begin
            ex_valid     <= 1'b1;
            data1        <= nxt_d1;
            data2        <= nxt_d2;
            aluoperation <= nxt_op;
            ex_dest      <= sel_dest;
         end else if (fire) begin
            ex_valid <= 1'b0;
         end

         if (to_skid) begin
            skid_valid   <= 1'b1;
            in_ready     <= 1'b0;
            skid_func    <= in_func;
            skid_rs      <= in_rs_data;
            skid_rt      <= in_rt_data;
            skid_imm     <= in_imm;
            skid_use_imm <= in_use_imm;
            skid_rs_fwd  <= in_rs_fwd;
            skid_rt_fwd  <= in_rt_fwd;
            skid_dest    <= in_dest;
         end else if (from_skid) begin
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
         end
      end
   end

`ifdef ALU_OP_ISSUE_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (fire)
            perf_issued <= perf_issued + 32'd1;
         if (ex_valid && !ex_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_op_issue;

   typedef struct {
      logic [2:0]  func;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic        use_imm;
      logic        rs_fwd;
      logic        rt_fwd;
      logic [4:0]  dest;
   } op_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_func;
   logic [31:0] in_rs_data;
   logic [31:0] in_rt_data;
   logic [15:0] in_imm;
   logic        in_use_imm;
   logic        in_rs_fwd;
   logic        in_rt_fwd;
   logic [4:0]  in_dest;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [3:0]  aluoperation;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_dest;
   logic [31:0] alu_result;
`ifdef ALU_OP_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
`endif

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   // reference model: in-order queue of accepted ops, head is the op in EX
   op_t         q[$];
   logic [31:0] m_d1, m_d2, m_last;
   logic [3:0]  m_op;
   logic [4:0]  m_dest;
   logic [31:0] m_pi, m_ps;

   alu_op_issue dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_func(in_func), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rs_fwd(in_rs_fwd),
      .in_rt_fwd(in_rt_fwd), .in_dest(in_dest),
      .data1(data1), .data2(data2), .aluoperation(aluoperation),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_dest(ex_dest),
      .alu_result(alu_result)
`ifdef ALU_OP_ISSUE_PERF_EN
      , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return a + b;
      endcase
   endfunction

   // the ALU downstream is modelled from the bench's own expected operands
   assign alu_result = alu_f(m_op, m_d1, m_d2);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_d1 = 0; m_d2 = 0; m_op = 0; m_dest = 0; m_last = 0; m_pi = 0; m_ps = 0;
   endtask

   task automatic model_edge();
      bit          was_empty, fire, acc;
      logic [31:0] res;
      op_t         o;
      was_empty = (q.size() == 0);
      fire      = !was_empty && ex_ready;
      acc       = in_valid && (q.size() < 2);
      res       = alu_result;
      if (!was_empty && !ex_ready) m_ps++;
      if (fire) begin
         m_pi++;
         void'(q.pop_front());
         m_last = res;
      end
      if (acc) begin
         o.func = in_func; o.rs = in_rs_data; o.rt = in_rt_data; o.imm = in_imm;
         o.use_imm = in_use_imm; o.rs_fwd = in_rs_fwd; o.rt_fwd = in_rt_fwd; o.dest = in_dest;
         q.push_back(o);
      end
      if ((fire || was_empty) && q.size() > 0) begin
         o      = q[0];
         m_d1   = o.rs_fwd ? m_last : o.rs;
         m_d2   = o.use_imm ? {{16{o.imm[15]}}, o.imm} : (o.rt_fwd ? m_last : o.rt);
         m_op   = (o.func <= 3'd4) ? {1'b0, o.func} : 4'd0;
         m_dest = o.dest;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1 model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [2:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input bit ui, input bit rf, input bit tf, input logic [4:0] d);
      in_valid = v; in_func = f; in_rs_data = rs; in_rt_data = rt; in_imm = imm;
      in_use_imm = ui; in_rs_fwd = rf; in_rt_fwd = tf; in_dest = d;
   endtask

   task automatic idle();
      drive(0, 3'd0, 32'd0, 32'd0, 16'd0, 0, 0, 0, 5'd0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ex_valid", {31'd0, ex_valid}, {31'd0, q.size() > 0});
         check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
         if (q.size() > 0) begin
            check("data1", data1, m_d1);
            check("data2", data2, m_d2);
            check("aluoperation", {28'd0, aluoperation}, {28'd0, m_op});
            check("ex_dest", {27'd0, ex_dest}, {27'd0, m_dest});
         end
`ifdef ALU_OP_ISSUE_PERF_EN
         check("perf_issued", perf_issued, m_pi);
         check("perf_stall", perf_stall, m_ps);
`endif
      end
   end

   initial begin
`ifdef ALU_OP_ISSUE_PERF_EN
      logic [31:0] ps0;
`endif
      reset = 1'b1;
      ex_ready = 1'b1;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst aluop", {28'd0, aluoperation}, 32'd0);
      check("rst data1", data1, 32'd0);
      check("rst data2", data2, 32'd0);
      chk_en = 1;

      // single SUB op
      drive(1, 3'd1, 32'd10, 32'd3, 16'd0, 0, 0, 0, 5'd5);
      tick();
      idle();
      check("t1 ex_valid", {31'd0, ex_valid}, 32'd1);
      check("t1 aluop", {28'd0, aluoperation}, 32'd1);
      check("t1 data1", data1, 32'd10);
      check("t1 data2", data2, 32'd3);
      check("t1 dest", {27'd0, ex_dest}, 32'd5);
      tick();
      check("t1 drained", {31'd0, ex_valid}, 32'd0);

      // immediate wins over rt forward, sign-extended
      drive(1, 3'd0, 32'd5, 32'd99, 16'hFFFF, 1, 0, 1, 5'd2);
      tick();
      idle();
      check("t2 data2", data2, 32'hFFFF_FFFF);
      check("t2 aluop", {28'd0, aluoperation}, 32'd0);
      check("t2 data1", data1, 32'd5);
      tick();

      // back-to-back forward on the producer's fire cycle
      drive(1, 3'd0, 32'd7, 32'd8, 16'd0, 0, 0, 0, 5'd3);
      tick();
      drive(1, 3'd1, 32'd0, 32'd5, 16'd0, 0, 1, 0, 5'd4);
      check("t3 alu_result", alu_result, 32'd15);
      tick();
      idle();
      check("t3 fwd data1", data1, 32'd15);
      check("t3 model last", m_last, 32'd15);
      check("t3 aluop", {28'd0, aluoperation}, 32'd1);
      tick();
      tick();
      // forward from held last_result (B produced 15-5)
      drive(1, 3'd0, 32'd0, 32'd1, 16'd0, 0, 1, 0, 5'd1);
      tick();
      idle();
      check("t3 held fwd", data1, 32'd10);
      tick();

      // stall with skid; an offer while full must be ignored
      ex_ready = 1'b0;
      drive(1, 3'd3, 32'd1, 32'd2, 16'd0, 0, 0, 0, 5'd6);
      tick();
      drive(1, 3'd2, 32'hF0, 32'h3C, 16'd0, 0, 0, 0, 5'd7);
      tick();
      check("t4 in_ready low", {31'd0, in_ready}, 32'd0);
      drive(1, 3'd4, 32'hDEAD, 32'hBEEF, 16'd0, 0, 0, 0, 5'd8);
      tick();
      idle();
      check("t4 hold data1", data1, 32'd1);
      check("t4 hold aluop", {28'd0, aluoperation}, 32'd3);
      check("t4 still full", {31'd0, in_ready}, 32'd0);
      ex_ready = 1'b1;
      tick();
      check("t4 in_ready back", {31'd0, in_ready}, 32'd1);
      check("t4 B data1", data1, 32'hF0);
      check("t4 B dest", {27'd0, ex_dest}, 32'd7);
      tick();
      check("t4 drained", {31'd0, ex_valid}, 32'd0);

      // forward resolved when B leaves the skid
      ex_ready = 1'b0;
      drive(1, 3'd4, 32'hFF, 32'hF0, 16'd0, 0, 0, 0, 5'd8);
      tick();
      drive(1, 3'd0, 32'd1, 32'd0, 16'd0, 0, 0, 1, 5'd9);
      tick();
      idle();
      tick();
      ex_ready = 1'b1;
      tick();
      check("t5 skid fwd data2", data2, 32'h0000_000F);
      tick();

      // async reset with both entries full
`ifdef ALU_OP_ISSUE_PERF_EN
      ps0 = perf_stall;
`endif
      ex_ready = 1'b0;
      drive(1, 3'd4, 32'h1234, 32'h5678, 16'd0, 0, 0, 0, 5'd10);
      tick();
      drive(1, 3'd1, 32'd9, 32'd4, 16'd0, 0, 0, 0, 5'd11);
      tick();
      idle();
      tick();
      check("t6 aluop before", {28'd0, aluoperation}, 32'd4);
      @(posedge clk);
      #1 model_edge();
`ifdef ALU_OP_ISSUE_PERF_EN
      check("t6 perf_stall", perf_stall - ps0, 32'd3);
`endif
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("t6 ex_valid", {31'd0, ex_valid}, 32'd0);
      check("t6 in_ready", {31'd0, in_ready}, 32'd1);
      check("t6 aluop", {28'd0, aluoperation}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ex_ready = 1'b1;
      // last_result cleared by reset
      drive(1, 3'd0, 32'd77, 32'd2, 16'd0, 0, 1, 0, 5'd12);
      tick();
      idle();
      check("t6 fwd after reset", data1, 32'd0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- ID/EX issue stage that drives the ALU's operand/opcode interface (data1, data2, aluoperation).
- Encodes a decoded 3-bit function select into the 4-bit ALU opcode and selects the immediate or register operand.
- Resolves back-to-back RAW dependencies by forwarding the ALU result.
- Decouples the decode stage from EX stalls with a valid/ready handshake and a 2-entry buffer: an output register plus a skid register.

Parameters:
- WIDTH, 32, datapath width.
- IMM_W, 16, immediate width; sign-extended to WIDTH.
- RA_W, 5, destination register address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  issue stage can accept an op.
- in_func  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 ADD.
- in_rs_data  in  WIDTH  register operand A.
- in_rt_data  in  WIDTH  register operand B.
- in_imm  in  IMM_W  immediate.
- in_use_imm  in  1  operand B = sign-extended in_imm.
- in_rs_fwd  in  1  operand A = result of previous issued op.
- in_rt_fwd  in  1  operand B = result of previous issued op; ignored when in_use_imm=1.
- in_dest  in  RA_W  destination register.
- data1  out  WIDTH  ALU operand A.
- data2  out  WIDTH  ALU operand B.
- aluoperation  out  4  ALU opcode.
- ex_valid  out  1  output register holds a valid op.
- ex_ready  in  1  EX/MEM accepts the op this cycle.
- ex_dest  out  RA_W  destination of the op in the output register.
- alu_result  in  WIDTH  combinational ALU result for the current data1/data2/aluoperation.

Behaviour:
- Reset, asynchronous: ex_valid=0, skid empty, data1=data2=0, aluoperation=4'b0000, ex_dest=0, last_result=0, in_ready=1.
- Opcode map: func 0→0000, 1→0001, 2→0010, 3→0011, 4→0100, 5/6/7→0000.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - EX fire = ex_valid & ex_ready.
  - in_ready = skid empty; it is a registered output.
- Buffering: latency 1 cycle from accept to ex_valid when the pipe is not stalled.
  - Accept while output register is empty, or output fires the same cycle → op loads directly into the output register.
  - Accept while output is full and not firing → op goes to skid; in_ready drops next cycle.
  - Output fires with skid full → skid moves to the output register; in_ready rises next cycle.
  - Order is strictly preserved; there is no bypass around the skid.
- last_result: captures alu_result on every EX fire; otherwise holds.
- Forwarding is resolved when an op is loaded into the output register, not at accept time. The skid stores the raw fwd flags and raw data.
  - Forwarded value = alu_result if EX fire this cycle, else last_result.
  - Covers the dependent arriving in the same cycle as the producer fires, or any later cycle.
- data2 priority: in_use_imm (sign-extended) > in_rt_fwd > in_rt_data.
- While ex_valid=1 and ex_ready=0, data1, data2, aluoperation and ex_dest are held stable.
- When ex_valid=0, outputs keep their last values; downstream ignores them.
- Simultaneous accept + fire + skid full is impossible, because in_ready=0.
- Reset mid-stall: all ops are dropped; last_result=0.

Optional Feature:
- Macro ALU_OP_ISSUE_PERF_EN.
- Defined:
  - Adds outputs perf_issued[31:0], which counts EX fires.
  - Adds perf_stall[31:0], which counts cycles with ex_valid & ~ex_ready.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Single op, ex_ready=1: func=1, rs=10, rt=3 → next cycle ex_valid=1, aluoperation=0001, data1=10, data2=3; ex_valid=0 the cycle after.
2. Immediate: func=0, rs=5, in_use_imm=1, imm=16'hFFFF, in_rt_fwd=1 → data2=32'hFFFFFFFF, aluoperation=0000.
3. Back-to-back forward:
   - Op A: ADD 7+8; on A's fire cycle, alu_result=15 is driven.
   - Op B accepted with in_rs_fwd=1 → B's data1=15.
   - last_result=15 afterwards.
4. Stall and skid:
   - Hold ex_ready=0, accept ops A, B → in_ready=0 after B; outputs hold A.
   - Release ex_ready → A fires, then B, in order; in_ready returns to 1.
5. Forward through skid:
   - Hold ex_ready=0, issue A (XOR, result 32'h0F), then B with in_rt_fwd=1.
   - Release ex_ready → B's data2=32'h0F.
6. Reset asserted during a stall with both entries full → asynchronously ex_valid=0, in_ready=1, aluoperation=0000. With ALU_OP_ISSUE_PERF_EN defined, also check perf_stall counts exactly the stalled cycles.
